// File: rtl/utlb_pkg.sv
// Shared widths, entry record and FSM state encoding for the micro-TLB.
package utlb_pkg;

  localparam int unsigned VADDR_W    = 32;
  localparam int unsigned PAGE_SHIFT = 12;
  localparam int unsigned VPN_W      = 20;
  localparam int unsigned PFN_W      = 20;
  localparam int unsigned OPTS_W     = 5;
  localparam int unsigned ASID_MAX_W = 16;

  // ASID is held at its widest supported size; narrower ASIDs are zero-extended.
  typedef struct packed {
    logic                  valid;
    logic [VPN_W-1:0]      vpn;
    logic [ASID_MAX_W-1:0] asid;
    logic                  g;
    logic [PFN_W-1:0]      pfn;
    logic [OPTS_W-1:0]     opts;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

endpackage

// File: rtl/utlb_if.sv
// Lookup (CPU side) and refill (JTLB side) signal bundle for the micro-TLB.
interface utlb_if
  import utlb_pkg::*;
#(
  parameter int unsigned ASID_W = 8
) ();

  logic                lookup_req_i;
  logic [VADDR_W-1:0]  lookup_vaddr_i;
  logic [ASID_W-1:0]   asid_i;
  logic                flush_i;
  logic                lookup_done_o;
  logic                lookup_fault_o;
  logic [VADDR_W-1:0]  lookup_paddr_o;
  logic [OPTS_W-1:0]   lookup_opts_o;
  logic                busy_o;
  logic                refill_req_o;
  logic [VADDR_W-1:0]  refill_vaddr_o;
  logic                refill_ack_i;
  logic                refill_hit_i;
  logic [PFN_W-1:0]    refill_pfn_i;
  logic [OPTS_W-1:0]   refill_opts_i;
  logic                refill_g_i;

  // Requester and JTLB together drive the master side.
  modport master (
    output lookup_req_i, lookup_vaddr_i, asid_i, flush_i,
           refill_ack_i, refill_hit_i, refill_pfn_i, refill_opts_i, refill_g_i,
    input  lookup_done_o, lookup_fault_o, lookup_paddr_o, lookup_opts_o,
           busy_o, refill_req_o, refill_vaddr_o
  );

  modport slave (
    input  lookup_req_i, lookup_vaddr_i, asid_i, flush_i,
           refill_ack_i, refill_hit_i, refill_pfn_i, refill_opts_i, refill_g_i,
    output lookup_done_o, lookup_fault_o, lookup_paddr_o, lookup_opts_o,
           busy_o, refill_req_o, refill_vaddr_o
  );

endinterface

// File: rtl/utlb_victim_sel.sv
// Picks the fill slot: lowest-index invalid entry, otherwise the round-robin pointer.
module utlb_victim_sel #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [ENTRIES-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   victim
);

  // Scan downwards so the lowest invalid index is the last one written.
  always_comb begin
    victim = ptr;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) victim = PTR_W'(i);
    end
  end

endmodule

// File: rtl/utlb.sv
// Fully associative micro-TLB with blocking JTLB refill, 4 KiB pages.
// Optional hit/miss counters are built when UTLB_STATS_EN is defined.
module utlb
  import utlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned ASID_W  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef UTLB_STATS_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  utlb_if.slave       bus
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);

  tlb_entry_t            entries_q [ENTRIES];
  logic [ENTRIES-1:0]    valid_vec;
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      victim;
  state_t                state_q;
  state_t                state_d;
  logic                  drop_q;
  logic [VADDR_W-1:0]    req_vaddr_q;
  logic [ASID_MAX_W-1:0] req_asid_q;
  logic [ASID_MAX_W-1:0] cur_asid;
  logic [VPN_W-1:0]      cur_vpn;
  logic                  hit;
  logic [PFN_W-1:0]      hit_pfn;
  logic [OPTS_W-1:0]     hit_opts;
  logic                  miss_start;
  logic                  fill_en;

  assign cur_asid = ASID_MAX_W'(bus.asid_i[ASID_W-1:0]);
  assign cur_vpn  = bus.lookup_vaddr_i[VADDR_W-1:PAGE_SHIFT];

  // Associative match; at most one entry can match, so the payload is OR-merged.
  always_comb begin
    valid_vec = '0;
    hit       = 1'b0;
    hit_pfn   = '0;
    hit_opts  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      if (entries_q[i].valid && (entries_q[i].vpn == cur_vpn) &&
          (entries_q[i].g || (entries_q[i].asid == cur_asid))) begin
        hit      = 1'b1;
        hit_pfn  = hit_pfn | entries_q[i].pfn;
        hit_opts = hit_opts | entries_q[i].opts;
      end
    end
  end

  utlb_victim_sel #(
    .ENTRIES (ENTRIES),
    .PTR_W   (PTR_W)
  ) u_victim_sel (
    .valid  (valid_vec),
    .ptr    (ptr_q),
    .victim (victim)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and lookup/refill outputs; a hit answers in the request cycle.
  always_comb begin
    state_d            = state_q;
    bus.lookup_done_o  = 1'b0;
    bus.lookup_fault_o = 1'b0;
    bus.lookup_paddr_o = '0;
    bus.lookup_opts_o  = '0;
    bus.busy_o         = 1'b0;
    bus.refill_req_o   = 1'b0;
    bus.refill_vaddr_o = '0;
    miss_start         = 1'b0;
    fill_en            = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.lookup_req_i) begin
          if (hit) begin
            if (!bus.flush_i) begin
              bus.lookup_done_o  = 1'b1;
              bus.lookup_paddr_o = {hit_pfn, bus.lookup_vaddr_i[PAGE_SHIFT-1:0]};
              bus.lookup_opts_o  = hit_opts;
            end
          end else begin
            miss_start = 1'b1;
            state_d    = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        bus.refill_req_o   = 1'b1;
        bus.refill_vaddr_o = req_vaddr_q;
        bus.busy_o         = 1'b1;
        if (bus.refill_ack_i) begin
          // Any flush seen during the refill discards the JTLB answer.
          if (drop_q || bus.flush_i) begin
            state_d = ST_IDLE;
          end else if (bus.refill_hit_i) begin
            fill_en = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        bus.lookup_done_o  = 1'b1;
        bus.lookup_fault_o = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry array, round-robin pointer, drop flag and latched miss context.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      ptr_q       <= '0;
      drop_q      <= 1'b0;
      req_vaddr_q <= '0;
      req_asid_q  <= '0;
    end else begin
      if (miss_start) begin
        req_vaddr_q <= bus.lookup_vaddr_i;
        req_asid_q  <= cur_asid;
      end
      if (state_q == ST_REFILL) drop_q <= (drop_q || bus.flush_i) && !bus.refill_ack_i;
      else                      drop_q <= 1'b0;
      if (bus.flush_i) begin
        for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
      end else if (fill_en) begin
        entries_q[victim] <= '{valid: 1'b1,
                               vpn:   req_vaddr_q[VADDR_W-1:PAGE_SHIFT],
                               asid:  req_asid_q,
                               g:     bus.refill_g_i,
                               pfn:   bus.refill_pfn_i,
                               opts:  bus.refill_opts_i};
        ptr_q <= ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef UTLB_STATS_EN
  logic hit_done_c;
  assign hit_done_c = (state_q == ST_IDLE) && bus.lookup_req_i && hit && !bus.flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_done_c) hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_utlb.sv
// Self-checking bench for utlb: directed table, hand-written corner sequences, random traffic.
module tb_utlb;

  localparam int NENT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  utlb_if #(.ASID_W(8)) bus ();
`ifdef UTLB_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  utlb #(.ENTRIES(NENT), .ASID_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
`ifdef UTLB_STATS_EN
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
`endif
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays of translations plus a fill counter.
  logic        m_valid [NENT];
  logic [19:0] m_vpn   [NENT];
  logic [7:0]  m_asid  [NENT];
  logic        m_g     [NENT];
  logic [19:0] m_pfn   [NENT];
  logic [4:0]  m_opts  [NENT];
  int          m_ptr;
  int          m_hits;
  int          m_misses;

  typedef struct {
    logic        rst;
    logic [31:0] va;
    logic [7:0]  as;
    logic        exp_hit;
    logic        ack_hit;
    logic [19:0] pfn;
    logic        g;
    logic [4:0]  op;
    int          dly;
    logic [31:0] exp_pa;
    logic [4:0]  exp_op;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
    m_ptr = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] va, input logic [7:0] as, input logic [19:0] pfn,
                            input logic g, input logic [4:0] op);
    int v;
    v = m_ptr;
    for (int i = NENT - 1; i >= 0; i--) if (!m_valid[i]) v = i;
    m_valid[v] = 1'b1; m_vpn[v] = va[31:12]; m_asid[v] = as;
    m_g[v] = g; m_pfn[v] = pfn; m_opts[v] = op;
    m_ptr = (m_ptr + 1) % NENT;
  endtask

  task automatic model_lookup(input logic [31:0] va, input logic [7:0] as, output logic h, output int idx);
    h = 1'b0; idx = 0;
    for (int i = 0; i < NENT; i++)
      if (m_valid[i] && m_vpn[i] == va[31:12] && (m_g[i] || m_asid[i] == as)) begin
        h = 1'b1; idx = i;
      end
  endtask

  function automatic logic vpn_present(input logic [19:0] vpn);
    vpn_present = 1'b0;
    for (int i = 0; i < NENT; i++) if (m_valid[i] && m_vpn[i] == vpn) vpn_present = 1'b1;
  endfunction

  task automatic stats_chk();
`ifdef UTLB_STATS_EN
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.lookup_req_i = 1'b0; bus.flush_i = 1'b0; bus.refill_ack_i = 1'b0;
    model_reset();
    #1;
    chk("rst_done", bus.lookup_done_o, 0);
    chk("rst_fault", bus.lookup_fault_o, 0);
    chk("rst_paddr", bus.lookup_paddr_o, 0);
    chk("rst_opts", bus.lookup_opts_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_refill_req", bus.refill_req_o, 0);
    chk("rst_refill_vaddr", bus.refill_vaddr_o, 0);
    stats_chk();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full request: lookup, optional refill of dly wait cycles, result, release.
  task automatic translate(input logic [31:0] va, input logic [7:0] as, input logic exp_hit,
                           input logic ack_hit, input logic [19:0] pfn, input logic g,
                           input logic [4:0] op, input int dly, input logic [31:0] exp_pa,
                           input logic [4:0] exp_op);
    @(negedge clk);
    bus.lookup_req_i = 1'b1; bus.lookup_vaddr_i = va; bus.asid_i = as;
    #1;
    if (exp_hit) begin
      chk("hit_done", bus.lookup_done_o, 1);
      chk("hit_paddr", bus.lookup_paddr_o, exp_pa);
      chk("hit_opts", bus.lookup_opts_o, exp_op);
      chk("hit_fault", bus.lookup_fault_o, 0);
      m_hits++;
    end else begin
      chk("miss_done", bus.lookup_done_o, 0);
      m_misses++;
      for (int c = 0; c < dly; c++) begin
        @(negedge clk); #1;
        chk("wait_refill_req", bus.refill_req_o, 1);
        chk("wait_busy", bus.busy_o, 1);
        chk("wait_refill_vaddr", bus.refill_vaddr_o, va);
        chk("wait_done", bus.lookup_done_o, 0);
      end
      @(negedge clk);
      bus.refill_ack_i = 1'b1; bus.refill_hit_i = ack_hit;
      bus.refill_pfn_i = pfn; bus.refill_g_i = g; bus.refill_opts_i = op;
      #1;
      chk("ack_refill_req", bus.refill_req_o, 1);
      chk("ack_refill_vaddr", bus.refill_vaddr_o, va);
      @(negedge clk);
      bus.refill_ack_i = 1'b0;
      #1;
      chk("post_ack_done", bus.lookup_done_o, 1);
      chk("post_ack_busy", bus.busy_o, 0);
      chk("post_ack_paddr", bus.lookup_paddr_o, exp_pa);
      chk("post_ack_opts", bus.lookup_opts_o, exp_op);
      chk("post_ack_fault", bus.lookup_fault_o, !ack_hit);
      if (ack_hit) begin
        model_fill(va, as, pfn, g, op);
        m_hits++;
      end
    end
    @(negedge clk);
    bus.lookup_req_i = 1'b0;
    #1;
    chk("release_done", bus.lookup_done_o, 0);
    chk("release_fault", bus.lookup_fault_o, 0);
    chk("release_refill_req", bus.refill_req_o, 0);
    stats_chk();
  endtask

  // Finish a refill already in progress with a JTLB hit; request is still held.
  task automatic complete_refill(input logic [31:0] va, input logic [7:0] as, input logic [19:0] pfn,
                                 input logic [4:0] op);
    @(negedge clk);
    bus.refill_ack_i = 1'b1; bus.refill_hit_i = 1'b1;
    bus.refill_pfn_i = pfn; bus.refill_g_i = 1'b0; bus.refill_opts_i = op;
    #1;
    chk("cr_refill_req", bus.refill_req_o, 1);
    @(negedge clk);
    bus.refill_ack_i = 1'b0;
    #1;
    model_fill(va, as, pfn, 1'b0, op);
    m_hits++;
    chk("cr_done", bus.lookup_done_o, 1);
    chk("cr_paddr", bus.lookup_paddr_o, {pfn, va[11:0]});
    @(negedge clk);
    bus.lookup_req_i = 1'b0;
    #1;
    chk("cr_release", bus.lookup_done_o, 0);
    stats_chk();
  endtask

  // Flush during refill, either one cycle before the ack or on the ack cycle.
  task automatic flush_refill(input logic [31:0] va, input logic [7:0] as, input logic coincide);
    @(negedge clk);
    bus.lookup_req_i = 1'b1; bus.lookup_vaddr_i = va; bus.asid_i = as;
    #1;
    chk("fr_miss_done", bus.lookup_done_o, 0);
    m_misses++;
    if (!coincide) begin
      @(negedge clk);
      bus.flush_i = 1'b1;
      #1;
      chk("fr_flush_refill_req", bus.refill_req_o, 1);
      model_flush();
    end
    @(negedge clk);
    bus.flush_i = coincide;
    bus.refill_ack_i = 1'b1; bus.refill_hit_i = 1'b1;
    bus.refill_pfn_i = 20'hABCDE; bus.refill_g_i = 1'b0; bus.refill_opts_i = 5'h1F;
    #1;
    chk("fr_ack_refill_req", bus.refill_req_o, 1);
    if (coincide) model_flush();
    @(negedge clk);
    bus.flush_i = 1'b0; bus.refill_ack_i = 1'b0;
    #1;
    chk("fr_remiss_done", bus.lookup_done_o, 0);
    chk("fr_remiss_busy", bus.busy_o, 0);
    m_misses++;
    @(negedge clk); #1;
    chk("fr_refill_req_again", bus.refill_req_o, 1);
    complete_refill(va, as, 20'h0F00D, 5'h06);
  endtask

  logic [31:0] va;
  logic [7:0]  as;
  logic [19:0] vpn;
  logic [19:0] pfn;
  logic [4:0]  op;
  logic        mh, ah, g;
  int          idx;

  initial begin
    bus.lookup_req_i = 1'b0; bus.lookup_vaddr_i = '0; bus.asid_i = '0; bus.flush_i = 1'b0;
    bus.refill_ack_i = 1'b0; bus.refill_hit_i = 1'b0; bus.refill_pfn_i = '0;
    bus.refill_opts_i = '0; bus.refill_g_i = 1'b0;
    model_reset();

    vecs[0]  = '{1'b1, 32'h0040_1234, 8'd5,   1'b0, 1'b1, 20'h1F0A0, 1'b0, 5'h0B, 2, 32'h1F0A_0234, 5'h0B};
    vecs[1]  = '{1'b0, 32'h0040_1ABC, 8'd5,   1'b1, 1'b0, 20'h0,     1'b0, 5'h00, 0, 32'h1F0A_0ABC, 5'h0B};
    vecs[2]  = '{1'b0, 32'h0040_1234, 8'd6,   1'b0, 1'b1, 20'h22222, 1'b1, 5'h1F, 0, 32'h2222_2234, 5'h1F};
    vecs[3]  = '{1'b0, 32'h0040_1FFF, 8'd7,   1'b1, 1'b0, 20'h0,     1'b0, 5'h00, 0, 32'h2222_2FFF, 5'h1F};
    vecs[4]  = '{1'b0, 32'h0040_1000, 8'hFF,  1'b1, 1'b0, 20'h0,     1'b0, 5'h00, 0, 32'h2222_2000, 5'h1F};
    vecs[5]  = '{1'b0, 32'h7FFF_F008, 8'd5,   1'b0, 1'b0, 20'h0,     1'b0, 5'h00, 1, 32'h0,         5'h00};
    vecs[6]  = '{1'b1, 32'h0001_0000, 8'd1,   1'b0, 1'b1, 20'h00100, 1'b0, 5'h03, 1, 32'h0010_0000, 5'h03};
    vecs[7]  = '{1'b0, 32'h0001_1004, 8'd1,   1'b0, 1'b1, 20'h00101, 1'b0, 5'h05, 0, 32'h0010_1004, 5'h05};
    vecs[8]  = '{1'b0, 32'h0001_2008, 8'd1,   1'b0, 1'b1, 20'h00102, 1'b0, 5'h07, 0, 32'h0010_2008, 5'h07};
    vecs[9]  = '{1'b0, 32'h0001_300C, 8'd1,   1'b0, 1'b1, 20'h00103, 1'b0, 5'h09, 0, 32'h0010_300C, 5'h09};
    vecs[10] = '{1'b0, 32'h0001_4010, 8'd1,   1'b0, 1'b1, 20'h00104, 1'b0, 5'h11, 0, 32'h0010_4010, 5'h11};
    vecs[11] = '{1'b0, 32'h0001_0000, 8'd1,   1'b0, 1'b1, 20'h00105, 1'b0, 5'h13, 0, 32'h0010_5000, 5'h13};
    vecs[12] = '{1'b0, 32'h0001_2FFF, 8'd1,   1'b1, 1'b0, 20'h0,     1'b0, 5'h00, 0, 32'h0010_2FFF, 5'h07};
    vecs[13] = '{1'b0, 32'h0001_1000, 8'd1,   1'b0, 1'b0, 20'h0,     1'b0, 5'h00, 0, 32'h0,         5'h00};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) apply_reset();
      translate(vecs[i].va, vecs[i].as, vecs[i].exp_hit, vecs[i].ack_hit, vecs[i].pfn,
                vecs[i].g, vecs[i].op, vecs[i].dly, vecs[i].exp_pa, vecs[i].exp_op);
    end

    // A resident translation is not reported without a request.
    @(negedge clk);
    bus.lookup_req_i = 1'b0; bus.lookup_vaddr_i = 32'h0001_2345; bus.asid_i = 8'd1;
    #1;
    chk("noreq_done", bus.lookup_done_o, 0);
    chk("noreq_refill_req", bus.refill_req_o, 0);

    // Flush in IDLE hides a same-cycle hit and empties the TLB.
    @(negedge clk);
    bus.lookup_req_i = 1'b1; bus.flush_i = 1'b1;
    #1;
    chk("idle_flush_done", bus.lookup_done_o, 0);
    model_flush();
    @(negedge clk);
    bus.lookup_req_i = 1'b0; bus.flush_i = 1'b0;
    translate(32'h0001_2345, 8'd1, 1'b0, 1'b1, 20'h00777, 1'b0, 5'h02, 0, 32'h0077_7345, 5'h02);

    flush_refill(32'h0005_0010, 8'd2, 1'b0);
    flush_refill(32'h0006_0020, 8'd3, 1'b1);

    // Reset during a refill drops the request and all entries.
    @(negedge clk);
    bus.lookup_req_i = 1'b1; bus.lookup_vaddr_i = 32'h0009_9000; bus.asid_i = 8'd1;
    #1;
    chk("rr_miss_done", bus.lookup_done_o, 0);
    @(negedge clk); #1;
    chk("rr_refill_req", bus.refill_req_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr_refill_req_in_reset", bus.refill_req_o, 0);
    chk("rr_busy_in_reset", bus.busy_o, 0);
    model_reset();
    @(negedge clk);
    bus.lookup_vaddr_i = 32'h0001_2345;
    #1;
    chk("rr_done_in_reset", bus.lookup_done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr_after_release_done", bus.lookup_done_o, 0);
    m_misses++;
    @(negedge clk); #1;
    chk("rr_refill_req_again", bus.refill_req_o, 1);
    chk("rr_refill_vaddr", bus.refill_vaddr_o, 32'h0001_2345);
    complete_refill(32'h0001_2345, 8'd1, 20'h00888, 5'h04);

    // Random traffic over a small VPN/ASID pool, checked against the model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        chk("rnd_flush_done", bus.lookup_done_o, 0);
        model_flush();
        @(negedge clk);
        bus.flush_i = 1'b0;
      end
      vpn = 20'h00300 + 20'($urandom_range(0, 7));
      va  = {vpn, 12'($urandom_range(0, 4095))};
      as  = 8'($urandom_range(1, 3));
      model_lookup(va, as, mh, idx);
      if (mh) begin
        translate(va, as, 1'b1, 1'b0, 20'h0, 1'b0, 5'h0, 0, {m_pfn[idx], va[11:0]}, m_opts[idx]);
      end else begin
        ah  = ($urandom_range(0, 4) != 0);
        pfn = 20'($urandom);
        op  = 5'($urandom);
        g   = !vpn_present(vpn) && ($urandom_range(0, 1) == 1);
        translate(va, as, 1'b0, ah, pfn, g, op, int'($urandom_range(0, 3)),
                  ah ? {pfn, va[11:0]} : 32'h0, ah ? op : 5'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/utlb.md
UTLB -- requirements
Module: utlb

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 4, meaning the number of fully associative entries; it SHALL be a power of two in the range 2..16.
REQ-002 The block SHALL have parameter ASID_W, default 8, meaning the address-space identifier width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port lookup_req_i, input, 1 bit: translation request, held by the requester until lookup_done_o.
REQ-006 The block SHALL have port lookup_vaddr_i, input, 32 bits: virtual address of the request.
REQ-007 The block SHALL have port asid_i, input, ASID_W bits: current ASID.
REQ-008 The block SHALL have port flush_i, input, 1 bit: invalidate all entries; pulsed on tlbwi/tlbwr.
REQ-009 The block SHALL have port lookup_done_o, output, 1 bit: result valid this cycle.
REQ-010 The block SHALL have port lookup_fault_o, output, 1 bit: JTLB miss (refill exception); qualified by lookup_done_o.
REQ-011 The block SHALL have port lookup_paddr_o, output, 32 bits: physical address.
REQ-012 The block SHALL have port lookup_opts_o, output, 5 bits: {C[2:0],D,V} of the matched entry.
REQ-013 The block SHALL have port busy_o, output, 1 bit: refill in progress (feeds cpu pause).
REQ-014 The block SHALL have port refill_req_o, output, 1 bit: request to JTLB.
REQ-015 The block SHALL have port refill_vaddr_o, output, 32 bits: address being refilled.
REQ-016 The block SHALL have port refill_ack_i, input, 1 bit: JTLB response valid, one-cycle pulse.
REQ-017 The block SHALL have port refill_hit_i, input, 1 bit: JTLB found a mapping.
REQ-018 The block SHALL have port refill_pfn_i, input, 20 bits: physical frame number.
REQ-019 The block SHALL have port refill_opts_i, input, 5 bits: {C,D,V}.
REQ-020 The block SHALL have port refill_g_i, input, 1 bit: global bit.

Function
REQ-021 Entry state SHALL be valid, VPN[19:0], ASID, G, PFN[19:0], opts; page size fixed at 4 KiB.
REQ-022 Match SHALL be valid && VPN==vaddr[31:12] && (G || ASID==asid_i); at most one entry matches.
REQ-023 On a hit in IDLE: lookup_done_o=1 combinationally the same cycle, lookup_paddr_o={PFN,vaddr[11:0]}, lookup_opts_o=entry opts, fault=0.
REQ-024 FSM states SHALL be IDLE, REFILL, FAULT; on a miss in IDLE, next state is REFILL, latching vaddr and asid.
REQ-025 In REFILL: refill_req_o=1, refill_vaddr_o=latched vaddr, busy_o=1, lookup_done_o=0; the FSM waits an unbounded number of cycles for refill_ack_i.
REQ-026 Ack with refill_hit_i=1 SHALL write the victim entry and return to IDLE; the held request then hits in the following cycle (miss-to-done latency = ack cycle + 1).
REQ-027 Ack with refill_hit_i=0 SHALL go to FAULT: for one cycle done=1, fault=1, paddr=0, no write; then IDLE.
REQ-028 Victim selection SHALL be the lowest-index invalid entry, else the round-robin pointer; the pointer increments on every fill and wraps ENTRIES-1 -> 0.
REQ-029 flush_i SHALL clear all valid bits at the next edge; the round-robin pointer is unchanged.
REQ-030 flush_i asserted in REFILL SHALL set a drop flag; the ack is still awaited but discarded, the FSM returns to IDLE, and the request misses again.
REQ-031 When flush_i and ack coincide, flush SHALL win: no write, return to IDLE.
REQ-032 flush_i in IDLE SHALL suppress the same-cycle hit (done=0).
REQ-033 lookup_req_i=0 SHALL force done=0, fault=0, and the FSM SHALL stay in IDLE.

Reset
REQ-034 While rst_i=0: all entries invalid, pointer=0, FSM=IDLE, drop=0, every output 0, counters 0; release is synchronous to clk_i.

Configuration
REQ-035 UTLB_STATS_EN defined: add outputs hit_cnt_o[31:0] (increments on each IDLE hit done) and miss_cnt_o[31:0] (increments on each IDLE->REFILL); both wrap at 2^32 and are cleared only by reset. Undefined: ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-036 Package utlb_pkg SHALL hold the entry struct typedef, the FSM state enum, and PAGE_SHIFT=12 / VPN_W=20 / PFN_W=20.
REQ-037 The block SHALL use one sub-module, utlb_victim_sel: valid vector + pointer -> victim index.

Verification
REQ-038 The bench SHALL cover: reset, lookup 0x0040_1234 asid 5; ack hit pfn 0x1F0A0, G=0 -> done 1 cycle after ack, paddr 0x1F0A_0234, miss_cnt=1.
REQ-039 The bench SHALL cover: repeat the lookup with asid 6 -> miss (refill_req_o=1); with G=1 refilled -> hit for any asid.
REQ-040 The bench SHALL cover: fill 5 distinct VPNs with ENTRIES=4 -> the 5th evicts entry 0; re-looking up the first VPN -> miss.
REQ-041 The bench SHALL cover: ack with refill_hit_i=0 -> exactly one cycle with done=1, fault=1, then IDLE.
REQ-042 The bench SHALL cover: flush one cycle before ack, and flush coincident with ack -> no entry written, the request re-misses, and refill_req_o reasserts.
REQ-043 The bench SHALL cover: rst_i low mid-REFILL -> refill_req_o=0 immediately and all entries invalid after release.
